// File: rtl/pulse_frame_receiver_pkg.sv
// Shared constants and state encoding for the pulse-counter readout receiver.
package pulse_rx_pkg;

  localparam int unsigned ADDR_W        = 3;
  localparam int unsigned WORD_W_DEF    = 16;
  localparam int unsigned NUM_CH_DEF    = 6;
  localparam int unsigned LAST_ADDR_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STORE = 2'd2
  } rx_state_t;

endpackage

// File: rtl/pulse_frame_receiver_shifter.sv
// Serial-to-parallel shifter with bit counter for one readout word (MSB first).
module serial_word_shifter #(
  parameter int unsigned NBITS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_en,
  input  logic             ser_data,
  output logic [NBITS-1:0] word,
  output logic             done
);

  localparam int unsigned CW = $clog2(NBITS + 1);

  logic [NBITS-1:0] shreg;
  logic [CW-1:0]    cnt;

  // word/done describe the word as it stands once the current bit is taken,
  // so the receiver can commit it on the same edge that accepts the last bit.
  always_comb begin
    word = {shreg[NBITS-2:0], ser_data};
    done = bit_en && !start && (cnt == CW'(NBITS - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (start) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (bit_en) begin
      shreg <= word;
      cnt   <= done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pulse_frame_receiver.sv
// Readout link receiver: rebuilds per-channel count words into a register bank.
// Optional even parity bit per word when PULSE_RX_PARITY_EN is defined.
module pulse_frame_receiver
  import pulse_rx_pkg::*;
#(
  parameter int unsigned WORD_W    = WORD_W_DEF,
  parameter int unsigned NUM_CH    = NUM_CH_DEF,
  parameter int unsigned LAST_ADDR = LAST_ADDR_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sl,
  input  logic [ADDR_W-1:0]        ch_addr,
  input  logic                     bit_en,
  input  logic                     ser_data,
  input  logic                     err_clr,
  output logic [NUM_CH*WORD_W-1:0] ch_data,
  output logic                     word_valid,
  output logic [ADDR_W-1:0]        word_addr,
  output logic                     frame_done,
  output logic                     err_abort,
  output logic                     err_addr,
  output logic                     err_par
);

`ifdef PULSE_RX_PARITY_EN
  localparam int unsigned NBITS = WORD_W + 1;
`else
  localparam int unsigned NBITS = WORD_W;
`endif

  rx_state_t         state;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] bank [NUM_CH];
  logic [NBITS-1:0]  sh_word;
  logic [WORD_W-1:0] data_word;
  logic              sh_done, take_bit, store_now, addr_ok, par_ok, store_ok;

  always_comb begin
    take_bit  = bit_en && (state == SHIFT);
    store_now = (state == SHIFT) && sh_done;
    addr_ok   = 32'(addr_q) < NUM_CH;
`ifdef PULSE_RX_PARITY_EN
    par_ok    = ~^sh_word;
    data_word = sh_word[NBITS-1:1];
`else
    par_ok    = 1'b1;
    data_word = sh_word;
`endif
    store_ok  = store_now && addr_ok && par_ok;
  end

  serial_word_shifter #(.NBITS(NBITS)) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .start    (sl),
    .bit_en   (take_bit),
    .ser_data (ser_data),
    .word     (sh_word),
    .done     (sh_done)
  );

  // The word is committed on the last-bit edge; STORE is the cycle its pulses are visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      word_valid <= 1'b0;
      word_addr  <= '0;
      frame_done <= 1'b0;
      err_abort  <= 1'b0;
      err_addr   <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      frame_done <= 1'b0;
      if (err_clr) begin
        err_abort <= 1'b0;
        err_addr  <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (sl) begin
            state  <= SHIFT;
            addr_q <= ch_addr;
          end
        end
        SHIFT: begin
          if (sl) begin
            err_abort <= 1'b1;
            addr_q    <= ch_addr;
          end else if (store_now) begin
            state <= STORE;
            if (store_ok) begin
              word_valid <= 1'b1;
              word_addr  <= addr_q;
              frame_done <= (addr_q == ADDR_W'(LAST_ADDR));
            end else if (!addr_ok) begin
              err_addr <= 1'b1;
            end
          end
        end
        STORE: begin
          if (sl) begin
            err_abort <= 1'b1;
            addr_q    <= ch_addr;
            state     <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_CH; k++) bank[k] <= '0;
    end else if (store_ok) begin
      for (int unsigned k = 0; k < NUM_CH; k++)
        if (addr_q == ADDR_W'(k)) bank[k] <= data_word;
    end
  end

  always_comb begin
    ch_data = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) ch_data[k*WORD_W +: WORD_W] = bank[k];
  end

`ifdef PULSE_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_par <= 1'b0;
    else if (store_now && !par_ok)
      err_par <= 1'b1;
    else if (err_clr)
      err_par <= 1'b0;
  end
`else
  assign err_par = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_frame_receiver.sv
// Directed, table-driven bench for pulse_frame_receiver (WORD_W=8, NUM_CH=6, LAST_ADDR=3).
module tb_pulse_frame_receiver;

  localparam int W = 8;
`ifdef PULSE_RX_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic          clk = 1'b0;
  logic          reset, sl, bit_en, ser_data, err_clr;
  logic [2:0]    ch_addr;
  logic [6*W-1:0] ch_data;
  logic          word_valid, frame_done, err_abort, err_addr, err_par;
  logic [2:0]    word_addr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [6*W-1:0] exp_bank;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    logic       exp_frame;
  } vec_t;
  vec_t frame_tbl [6];

  always #5 clk = ~clk;

  pulse_frame_receiver #(.WORD_W(8), .NUM_CH(6), .LAST_ADDR(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .sl         (sl),
    .ch_addr    (ch_addr),
    .bit_en     (bit_en),
    .ser_data   (ser_data),
    .err_clr    (err_clr),
    .ch_data    (ch_data),
    .word_valid (word_valid),
    .word_addr  (word_addr),
    .frame_done (frame_done),
    .err_abort  (err_abort),
    .err_addr   (err_addr),
    .err_par    (err_par)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns 1ns after the edge that accepted the last bit.
  task automatic send_bits(input logic [2:0] a, input logic [NB-1:0] w, input bit gaps);
    sl = 1'b1; ch_addr = a; bit_en = 1'b1; ser_data = 1'b1;
    tick();
    sl = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (gaps && (i % 3 == 1)) begin
        bit_en = 1'b0; ser_data = ~ser_data;
        tick();
      end
      bit_en = 1'b1; ser_data = w[NB-1-i];
      tick();
    end
    bit_en = 1'b0;
  endtask

  task automatic send_word(input logic [2:0] a, input logic [7:0] d, input bit gaps);
    logic [NB-1:0] w;
`ifdef PULSE_RX_PARITY_EN
    w = {d, ^d};
`else
    w = d;
`endif
    send_bits(a, w, gaps);
  endtask

  initial begin
    frame_tbl[0] = '{3'd0, 8'h11, 1'b0};
    frame_tbl[1] = '{3'd4, 8'h44, 1'b0};
    frame_tbl[2] = '{3'd0, 8'h10, 1'b0};
    frame_tbl[3] = '{3'd1, 8'h22, 1'b0};
    frame_tbl[4] = '{3'd2, 8'h33, 1'b0};
    frame_tbl[5] = '{3'd3, 8'h3C, 1'b1};

    reset = 1'b1; sl = 1'b0; bit_en = 1'b0; ser_data = 1'b0; err_clr = 1'b0; ch_addr = '0;
    exp_bank = '0;
    tick(); tick();
    check("rst_ch_data", ch_data, 0);
    check("rst_valid", word_valid, 0);
    check("rst_frame", frame_done, 0);
    check("rst_addr", word_addr, 0);
    check("rst_err_abort", err_abort, 0);
    check("rst_err_addr", err_addr, 0);
    check("rst_err_par", err_par, 0);
    reset = 1'b0;
    tick();

    // 1: single word with bit_en gaps
    send_word(3'd2, 8'hA5, 1'b1);
    exp_bank[2*W +: W] = 8'hA5;
    check("t1_valid", word_valid, 1);
    check("t1_frame", frame_done, 0);
    check("t1_word_addr", word_addr, 2);
    check("t1_ch_data", ch_data, exp_bank);
    tick();
    check("t1_valid_pulse", word_valid, 0);

    // 2: full frame from table
    for (int i = 0; i < 6; i++) begin
      send_word(frame_tbl[i].addr, frame_tbl[i].data, i[0]);
      exp_bank[frame_tbl[i].addr*W +: W] = frame_tbl[i].data;
      check("t2_valid", word_valid, 1);
      check("t2_frame", frame_done, frame_tbl[i].exp_frame);
      check("t2_word_addr", word_addr, frame_tbl[i].addr);
      tick();
      check("t2_valid_off", word_valid, 0);
      check("t2_frame_off", frame_done, 0);
    end
    check("t2_bank", ch_data, 48'h0000_3C33_2210 | (48'h44 << 32));
    check("t2_bank_model", ch_data, exp_bank);
    check("t2_err_abort", err_abort, 0);

    // 3: abort after 3 bits, then a clean word to channel 5
    sl = 1'b1; ch_addr = 3'd1; tick(); sl = 1'b0;
    bit_en = 1'b1;
    for (int i = 0; i < 3; i++) begin ser_data = 1'b1; tick(); end
    send_word(3'd5, 8'hFF, 1'b0);
    exp_bank[5*W +: W] = 8'hFF;
    check("t3_valid", word_valid, 1);
    check("t3_word_addr", word_addr, 5);
    check("t3_bank", ch_data, exp_bank);
    check("t3_err_abort", err_abort, 1);
    tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t3_err_clr", err_abort, 0);

    // 4: out-of-range addresses; err_clr coincident with a new error keeps the flag
    send_word(3'd6, 8'h77, 1'b0);
    check("t4_valid", word_valid, 0);
    check("t4_err_addr", err_addr, 1);
    check("t4_bank", ch_data, exp_bank);
    tick();
    err_clr = 1'b1;
    send_word(3'd7, 8'h12, 1'b0);
    check("t4_clr_vs_err", err_addr, 1);
    check("t4_valid7", word_valid, 0);
    tick();
    check("t4_clr_after", err_addr, 0);
    err_clr = 1'b0;
    check("t4_bank7", ch_data, exp_bank);

    // 5: reset during bit 5
    sl = 1'b1; ch_addr = 3'd0; tick(); sl = 1'b0;
    bit_en = 1'b1;
    for (int i = 0; i < 4; i++) begin ser_data = i[0]; tick(); end
    ser_data = 1'b1;
    #2 reset = 1'b1;
    #1;
    exp_bank = '0;
    check("t5_ch_data", ch_data, 0);
    check("t5_valid", word_valid, 0);
    check("t5_word_addr", word_addr, 0);
    check("t5_err_addr", err_addr, 0);
    #2 reset = 1'b0;
    bit_en = 1'b0;
    tick();
    send_word(3'd0, 8'h5A, 1'b0);
    exp_bank[0 +: W] = 8'h5A;
    check("t5_valid_after", word_valid, 1);
    check("t5_bank", ch_data, exp_bank);
    tick();

`ifdef PULSE_RX_PARITY_EN
    // 6: parity good then bad
    send_bits(3'd2, {8'h07, 1'b1}, 1'b0);
    exp_bank[2*W +: W] = 8'h07;
    check("t6_good_valid", word_valid, 1);
    check("t6_good_bank", ch_data, exp_bank);
    check("t6_good_err", err_par, 0);
    tick();
    send_bits(3'd2, {8'h07, 1'b0}, 1'b0);
    check("t6_bad_valid", word_valid, 0);
    check("t6_bad_err", err_par, 1);
    check("t6_bad_bank", ch_data, exp_bank);
    tick();
`else
    check("t6_err_par_tied", err_par, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
